// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Byte offsets from the peripheral base address.
   localparam int unsigned TXDATA_OFF = 0;
   localparam int unsigned STATUS_OFF = 4;

   // STATUS register bit positions.
   localparam int unsigned BUSY        = 0;
   localparam int unsigned EMPTY       = 1;
   localparam int unsigned FULL        = 2;
   localparam int unsigned OVF         = 3;
   localparam int unsigned STATUS_BITS = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word fall-through read data.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         pop_data_c,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_n;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is legal when the same cycle frees a slot.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      count_n = count;
      if (do_push && !do_pop)
         count_n = count + CNT_W'(1);
      else if (do_pop && !do_push)
         count_n = count - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_n;
         full  <= (count_n == CNT_W'(DEPTH));
         empty <= (count_n == CNT_W'(0));
      end
   end

   // Storage carries no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   assign pop_data_c = mem[rd_ptr];

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS register, TX FIFO and bit-timing FSM.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [8:0]  BASE_ADDR    = 9'h1F0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic              rd,
   input  logic [8:0]        addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              hit_o,
   output logic              tx_o,
   output logic              busy_o
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [6:0]  TXDATA_WORD = BASE_ADDR[8:2] + 7'(TXDATA_OFF / 4);
   localparam logic [6:0]  STATUS_WORD = BASE_ADDR[8:2] + 7'(STATUS_OFF / 4);

   uart_state_t       state;
   uart_state_t       state_n;
   logic [BAUD_W-1:0] baud;
   logic [BAUD_W-1:0] baud_n;
   logic [2:0]        bit_idx;
   logic [2:0]        bit_idx_n;
   logic [7:0]        shift;
   logic [7:0]        shift_n;
   logic              tx_q;
   logic              tx_n;
   logic              baud_end;

   logic              sel_tx;
   logic              sel_st;
   logic              tx_wr;
   logic              st_wr;
   logic              overflow;

   logic              pop;
   logic              push;
   logic [7:0]        fifo_data;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   logic [STATUS_BITS-1:0] status;
   logic                   unused_bits;

   // Register decode on word address.
   assign sel_tx = (addr[8:2] == TXDATA_WORD);
   assign sel_st = (addr[8:2] == STATUS_WORD);
   assign hit_o  = sel_tx | sel_st;
   assign tx_wr  = wr & sel_tx;
   assign st_wr  = wr & sel_st;

   assign push = tx_wr & (~fifo_full | pop);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .push_data  (wr_data[7:0]),
      .pop_data_c (fifo_data),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   // Sticky overflow: set on a dropped byte, cleared by writing 1 to STATUS[OVF].
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         overflow <= 1'b0;
      else if (tx_wr && fifo_full && !pop)
         overflow <= 1'b1;
      else if (st_wr && wr_data[OVF])
         overflow <= 1'b0;
   end

   always_comb begin
      status        = '0;
      status[BUSY]  = (state != IDLE);
      status[EMPTY] = fifo_empty;
      status[FULL]  = fifo_full;
      status[OVF]   = overflow;
   end

   assign rd_data_o = (rd && sel_st) ? DATA_W'(status) : '0;
   assign busy_o    = (state != IDLE) | ~fifo_empty;
   assign tx_o      = tx_q;

   assign baud_end = (baud == BAUD_W'(CLKS_PER_BIT - 1));

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         tx_q    <= tx_n;
      end
   end

   // Next-state logic; tx_n is the line level for the bit about to start.
   always_comb begin
      state_n   = state;
      baud_n    = baud;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      tx_n      = tx_q;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            baud_n = '0;
            tx_n   = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_n = fifo_data;
               tx_n    = 1'b0;
               state_n = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_n    = '0;
               bit_idx_n = '0;
               tx_n      = shift[0];
               state_n   = DATA;
            end else begin
               baud_n = baud + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_n = '0;
               if (bit_idx == 3'd7) begin
                  tx_n    = 1'b1;
                  state_n = STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  shift_n   = {1'b0, shift[7:1]};
                  tx_n      = shift[1];
               end
            end else begin
               baud_n = baud + BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_n = '0;
               // Back-to-back frames: the next start bit follows the stop bit directly.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_n = fifo_data;
                  tx_n    = 1'b0;
                  state_n = START;
               end else begin
                  tx_n    = 1'b1;
                  state_n = IDLE;
               end
            end else begin
               baud_n = baud + BAUD_W'(1);
            end
         end
         default: begin
            tx_n    = 1'b1;
            state_n = IDLE;
         end
      endcase
   end

   assign unused_bits = ^{wr_data[DATA_W-1:8], addr[1:0], fifo_count};

endmodule
